ts_packet_mux_4ch: RTL and testbench

//  Read-side consumer for the four per-tuner packet buffers. Polls each channel's
//  GOT_FULL_PACKET, issues a 1-cycle GIVE_ME_ONE_PACKET and collects the 188-byte

---
 rtl/ts_packet_mux_4ch_pkg.sv | 21 ++
 rtl/ts_packet_mux_4ch_rr_arbiter_4.sv | 31 +++
 rtl/ts_packet_mux_4ch.sv | 164 ++++++++++++++++
 tb/tb_ts_packet_mux_4ch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_packet_mux_4ch_pkg.sv
// ----------------------------------------------------------------------------
// ts_packet_mux_4ch_pkg
// Shared constants and FSM encoding for the 4-channel TS packet multiplexer.
// ----------------------------------------------------------------------------
package ts_packet_mux_4ch_pkg;

    localparam int          NUM_CH     = 4;
    localparam int          PKT_LEN    = 188;   // bytes per TS packet
    localparam int          RD_LATENCY = 2;     // GIVE high -> byte 0 on DATA_IN (>=2)
    localparam int          MIN_GAP    = 4;     // idle cycles between packets (>=1)
    localparam logic [7:0]  SYNC_BYTE  = 8'h47;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LAT,
        ST_STREAM,
        ST_GAP
    } state_e;

endpackage

// File: rtl/ts_packet_mux_4ch_rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4
// Combinational round-robin pick: first set bit of eligible searching
// ptr+1, ptr+2, ptr+3, ptr (mod 4).
//  eligible [3:0] in  : request vector
//  ptr      [1:0] in  : last granted channel
//  sel      [1:0] out : chosen channel (0 when none)
//  any            out : at least one request
// ----------------------------------------------------------------------------
module rr_arbiter_4 (
    input  logic [3:0] eligible,
    input  logic [1:0] ptr,
    output logic [1:0] sel,
    output logic       any
);

    always_comb begin
        sel = '0;
        any = 1'b0;
        // Walk from farthest to nearest so the nearest hit after ptr wins.
        for (int i = 4; i >= 1; i--) begin
            logic [1:0] idx;
            idx = ptr + 2'(i);
            if (eligible[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ts_packet_mux_4ch.sv
// ----------------------------------------------------------------------------
// ts_packet_mux_4ch
// Reads whole packets out of four tuner buffers one at a time (round-robin)
// and re-emits them as a single TS stream with channel tag and sync check.
//  SYS_CLK            in  : clock
//  RST                in  : async active-low reset
//  CH_EN        [3:0] in  : per-channel enable
//  GOT_FULL_PACKET [3:0] in : buffer holds a complete packet
//  DATA_IN     [31:0] in  : channel k byte on [8k+7:8k]
//  GIVE_ME_ONE_PACKET [3:0] out : one-hot 1-cycle read request
//  TS_DATA      [7:0] out : stream byte
//  TS_VALID           out : byte valid (good-sync packets only)
//  TS_PSYNC           out : first byte of a forwarded packet
//  TS_CH        [1:0] out : source channel
//  SYNC_ERR           out : byte 0 of a packet was not the sync byte
// ----------------------------------------------------------------------------
module ts_packet_mux_4ch
    import ts_packet_mux_4ch_pkg::*;
(
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic [NUM_CH-1:0] GOT_FULL_PACKET,
    input  logic [31:0]       DATA_IN,
    output logic [NUM_CH-1:0] GIVE_ME_ONE_PACKET,
    output logic [7:0]        TS_DATA,
    output logic              TS_VALID,
    output logic              TS_PSYNC,
    output logic [1:0]        TS_CH,
    output logic              SYNC_ERR
);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;        // LAT / STREAM / GAP cycle counter
    logic [1:0]        sel_q, sel_d;        // channel being read
    logic [1:0]        ptr_q, ptr_d;        // last granted channel
    logic              pkt_ok_q, pkt_ok_d;  // current packet had a good sync byte
    logic [NUM_CH-1:0] give_q, give_d;
    logic [7:0]        ts_data_q, ts_data_d;
    logic              ts_valid_q, ts_valid_d;
    logic              ts_psync_q, ts_psync_d;
    logic [1:0]        ts_ch_q, ts_ch_d;
    logic              sync_err_q, sync_err_d;

    logic [NUM_CH-1:0][7:0] din;
    logic [7:0]             byte_in;
    logic [1:0]             arb_sel;
    logic                   arb_any;
    logic                   sync_ok;

    assign din     = DATA_IN;
    assign byte_in = din[sel_q];
    assign sync_ok = (byte_in == SYNC_BYTE);

    rr_arbiter_4 u_arb (
        .eligible (GOT_FULL_PACKET & CH_EN),
        .ptr      (ptr_q),
        .sel      (arb_sel),
        .any      (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        pkt_ok_d   = pkt_ok_q;
        give_d     = '0;
        ts_data_d  = '0;
        ts_valid_d = 1'b0;
        ts_psync_d = 1'b0;
        ts_ch_d    = '0;
        sync_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    give_d  = NUM_CH'(1) << arb_sel;
                    sel_d   = arb_sel;
                    ptr_d   = arb_sel;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_LAT;
            end
            // REQ already used one latency cycle; LAT covers the rest.
            ST_LAT: begin
                if (cnt_q == 8'(RD_LATENCY - 2)) begin
                    cnt_d   = '0;
                    state_d = ST_STREAM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STREAM: begin
                ts_ch_d = sel_q;
                if (cnt_q == 8'd0) begin
                    pkt_ok_d   = sync_ok;
                    sync_err_d = !sync_ok;
                    ts_valid_d = sync_ok;
                    ts_psync_d = sync_ok;
                    ts_data_d  = sync_ok ? byte_in : 8'h00;
                end else begin
                    // Bad packets are drained from the buffer but not forwarded.
                    ts_valid_d = pkt_ok_q;
                    ts_data_d  = pkt_ok_q ? byte_in : 8'h00;
                end
                if (cnt_q == 8'(PKT_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'(MIN_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= 2'd3;     // so channel 0 is searched first
            pkt_ok_q   <= 1'b0;
            give_q     <= '0;
            ts_data_q  <= '0;
            ts_valid_q <= 1'b0;
            ts_psync_q <= 1'b0;
            ts_ch_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            pkt_ok_q   <= pkt_ok_d;
            give_q     <= give_d;
            ts_data_q  <= ts_data_d;
            ts_valid_q <= ts_valid_d;
            ts_psync_q <= ts_psync_d;
            ts_ch_q    <= ts_ch_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign GIVE_ME_ONE_PACKET = give_q;
    assign TS_DATA            = ts_data_q;
    assign TS_VALID           = ts_valid_q;
    assign TS_PSYNC           = ts_psync_q;
    assign TS_CH              = ts_ch_q;
    assign SYNC_ERR           = sync_err_q;

endmodule

// File: tb/tb_ts_packet_mux_4ch.sv
// ----------------------------------------------------------------------------
// tb_ts_packet_mux_4ch
// Buffer model feeds queued packets; a stream-level reference model predicts
// grants (round-robin, one packet per 195 cycles) and every output slot.
// ----------------------------------------------------------------------------
module tb_ts_packet_mux_4ch;

    localparam int PKT = 188;
    localparam int PERIOD = 1 + 2 + PKT + 4;   // GIVE-to-GIVE when saturated

    logic        SYS_CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  CH_EN = 4'hF;
    logic [3:0]  GOT_FULL_PACKET = 4'h0;
    logic [31:0] DATA_IN = '0;
    logic [3:0]  GIVE_ME_ONE_PACKET;
    logic [7:0]  TS_DATA;
    logic        TS_VALID, TS_PSYNC, SYNC_ERR;
    logic [1:0]  TS_CH;

    ts_packet_mux_4ch dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .CH_EN(CH_EN),
        .GOT_FULL_PACKET(GOT_FULL_PACKET), .DATA_IN(DATA_IN),
        .GIVE_ME_ONE_PACKET(GIVE_ME_ONE_PACKET), .TS_DATA(TS_DATA),
        .TS_VALID(TS_VALID), .TS_PSYNC(TS_PSYNC), .TS_CH(TS_CH),
        .SYNC_ERR(SYNC_ERR)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // packet descriptor: bit16 = bad sync byte, [7:0] = payload seed
    int q [4][$];
    int rd_start [4];
    int rd_desc [4];

    // reference model state
    int m_ptr = 3;
    int m_last = -100000;
    bit act = 0;
    int a_start, a_ch, a_desc;
    logic [3:0] prev_elig;
    logic prev_rst;

    function automatic logic [7:0] pbyte(int d, int k);
        if (k == 0) return d[16] ? 8'h00 : 8'h47;
        return 8'(k + (d & 'hff) * 7);
    endfunction

    task automatic chk(string nm, logic [31:0] act_v, logic [31:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act_v, exp_v);
        end
    endtask

    task automatic model_check();
        logic [3:0] eg;
        logic [7:0] ed, ad;
        logic ev, ep, ee;
        logic [1:0] ec;
        int k;
        if (!prev_rst) begin
            m_ptr = 3; m_last = -100000; act = 0;
        end
        eg = '0;
        if (prev_rst && (cyc - 1 - m_last) >= PERIOD - 1 && prev_elig != 0) begin
            for (int i = 1; i <= 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (prev_elig[c]) begin
                    eg[c] = 1'b1; m_ptr = c; break;
                end
            end
            m_last = cyc; act = 1; a_start = cyc + 3; a_ch = m_ptr;
            a_desc = (q[m_ptr].size() > 0) ? q[m_ptr][0] : 0;
        end
        chk("give", 32'(GIVE_ME_ONE_PACKET), 32'(eg));
        ed = 0; ev = 0; ep = 0; ee = 0; ec = 0; ad = TS_DATA;
        if (act && cyc >= a_start && cyc < a_start + PKT) begin
            k = cyc - a_start;
            ec = 2'(a_ch);
            if (!a_desc[16]) begin
                ev = 1; ep = (k == 0); ed = pbyte(a_desc, k);
            end else begin
                ee = (k == 0); ad = 8'h00;   // data content of a dropped packet is don't-care
            end
            if (k == PKT - 1) act = 0;
        end
        chk("ts_out", 32'({ad, TS_VALID, TS_PSYNC, TS_CH, SYNC_ERR}),
                      32'({ed, ev, ep, ec, ee}));
    endtask

    task automatic tick();
        logic [3:0][7:0] dv;
        logic [3:0] got;
        @(posedge SYS_CLK);
        prev_elig = GOT_FULL_PACKET & CH_EN;
        prev_rst  = RST;
        #1;
        cyc++;
        model_check();
        dv = '0;
        for (int k = 0; k < 4; k++) begin
            int off;
            got[k] = (q[k].size() > 0) && (rd_start[k] < 0);   // drops the cycle after GIVE
            if (RST && GIVE_ME_ONE_PACKET[k] && rd_start[k] < 0 && q[k].size() > 0) begin
                rd_desc[k] = q[k].pop_front();
                rd_start[k] = cyc;
            end
            if (rd_start[k] >= 0) begin
                off = cyc - rd_start[k] - 2;
                if (off >= 0 && off < PKT) dv[k] = pbyte(rd_desc[k], off);
                if (off == PKT - 1) rd_start[k] = -1;
            end
        end
        GOT_FULL_PACKET = got;
        DATA_IN = dv;
    endtask

    task automatic begin_test(logic [3:0] en);
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            q[k].delete(); rd_start[k] = -1;
        end
        CH_EN = en;
        tick();
    endtask

    task automatic release_rst();
        tick(); tick();
        chk("reset_state", 32'({GIVE_ME_ONE_PACKET, TS_DATA, TS_VALID, TS_PSYNC, TS_CH, SYNC_ERR}), 32'd0);
        RST = 1'b1;
    endtask

    task automatic wait_give(int lim, output int ch, output int gc);
        ch = -1; gc = cyc;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (GIVE_ME_ONE_PACKET != 0) begin
                for (int k = 0; k < 4; k++) if (GIVE_ME_ONE_PACKET[k]) ch = k;
                gc = cyc;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL give_timeout cyc=%0d got=none exp=grant within %0d", cyc, lim);
    endtask

    typedef struct {
        logic [3:0] en;
        logic [3:0] got;
        logic [3:0] exp_give;
    } vec_t;

    initial begin
        vec_t vt [8];
        int ch, g, g0, nv;
        for (int k = 0; k < 4; k++) rd_start[k] = -1;
        vt[0] = '{4'hF, 4'b0100, 4'b0100};
        vt[1] = '{4'hE, 4'b0001, 4'b0000};
        vt[2] = '{4'hF, 4'b1111, 4'b0001};
        vt[3] = '{4'hF, 4'b1010, 4'b0010};
        vt[4] = '{4'hC, 4'b1011, 4'b1000};
        vt[5] = '{4'h0, 4'b1111, 4'b0000};
        vt[6] = '{4'h8, 4'b1000, 4'b1000};
        vt[7] = '{4'h6, 4'b1101, 4'b0100};

        // first grant after reset from a set of ready/enabled channels
        foreach (vt[i]) begin
            begin_test(vt[i].en);
            for (int k = 0; k < 4; k++) if (vt[i].got[k]) q[k].push_back(0);
            release_rst();
            tick();
            chk("tbl_first_give", 32'(GIVE_ME_ONE_PACKET), 32'(vt[i].exp_give));
        end

        // 1: single packet on ch2, byte pattern 47,01..BB
        begin_test(4'hF);
        q[2].push_back(0);
        release_rst();
        wait_give(20, ch, g);
        chk("t1_give", 32'(GIVE_ME_ONE_PACKET), 32'h4);
        repeat (3) tick();
        chk("t1_byte0", 32'({TS_DATA, TS_PSYNC, TS_VALID, TS_CH}), 32'({8'h47, 1'b1, 1'b1, 2'd2}));
        repeat (PKT - 1) tick();
        chk("t1_last", 32'({TS_DATA, TS_PSYNC, TS_VALID, TS_CH}), 32'({8'hBB, 1'b0, 1'b1, 2'd2}));
        tick();
        chk("t1_after", 32'({TS_VALID, TS_PSYNC}), 32'd0);

        // 2: all channels always ready -> 0,1,2,3,0 at full rate
        begin_test(4'hF);
        for (int k = 0; k < 4; k++) begin q[k].push_back(k + 1); q[k].push_back(k + 5); end
        release_rst();
        g0 = 0;
        for (int i = 0; i < 5; i++) begin
            wait_give(400, ch, g);
            chk("t2_order", 32'(ch), 32'(i % 4));
            if (i > 0) chk("t2_spacing", 32'(g - g0), 32'(PERIOD));
            g0 = g;
        end

        // 3: bad sync byte on ch1, ch2 served next
        begin_test(4'hF);
        q[1].push_back(32'h10003);
        q[2].push_back(9);
        release_rst();
        wait_give(20, ch, g);
        chk("t3_first", 32'(ch), 32'd1);
        repeat (3) tick();
        chk("t3_syncerr", 32'({SYNC_ERR, TS_VALID, TS_PSYNC}), 32'b100);
        tick();
        chk("t3_noval", 32'({SYNC_ERR, TS_VALID}), 32'd0);
        wait_give(400, ch, g0);
        chk("t3_next", 32'(ch), 32'd2);
        chk("t3_spacing", 32'(g0 - g), 32'(PERIOD));

        // 4: only disabled ch0 ready -> never granted
        begin_test(4'hE);
        q[0].push_back(0);
        release_rst();
        nv = 0;
        repeat (400) begin
            tick();
            if (GIVE_ME_ONE_PACKET != 0 || TS_VALID) nv++;
        end
        chk("t4_no_give", 32'(nv), 32'd0);
        chk("t4_got_held", 32'(GOT_FULL_PACKET[0]), 32'd1);

        // 5: reset at byte 90, ch0 first again after release
        begin_test(4'hF);
        q[0].push_back(2); q[0].push_back(3); q[1].push_back(4);
        release_rst();
        wait_give(20, ch, g);
        chk("t5_first", 32'(ch), 32'd0);
        repeat (3 + 90) tick();
        chk("t5_byte90", 32'({TS_VALID, TS_DATA}), 32'({1'b1, pbyte(2, 90)}));
        RST = 1'b0;
        for (int k = 0; k < 4; k++) rd_start[k] = -1;   // partial packet lost
        #1;
        chk("t5_async", 32'({GIVE_ME_ONE_PACKET, TS_DATA, TS_VALID, TS_PSYNC, TS_CH, SYNC_ERR}), 32'd0);
        release_rst();
        wait_give(20, ch, g);
        chk("t5_after_rst", 32'(ch), 32'd0);

        // 6: enable of the active channel dropped mid-packet
        begin_test(4'hF);
        q[3].push_back(11);
        release_rst();
        wait_give(20, ch, g);
        nv = 0;
        repeat (50) begin tick(); if (TS_VALID) nv++; end
        CH_EN = 4'h0;
        repeat (200) begin tick(); if (TS_VALID) nv++; end
        chk("t6_full_pkt", 32'(nv), 32'(PKT));

        // randomized traffic against the reference model
        begin_test(4'hF);
        release_rst();
        repeat (6000) begin
            tick();
            if ($urandom_range(0, 19) == 0) begin
                int c;
                c = $urandom_range(0, 3);
                if (q[c].size() < 3)
                    q[c].push_back(($urandom_range(0, 5) == 0 ? 32'h10000 : 0) | $urandom_range(0, 255));
            end
            if ($urandom_range(0, 99) == 0) CH_EN = 4'($urandom_range(0, 15));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
